servile_mem_arbiter: RTL and testbench

//  Two-master Wishbone arbiter sharing the single servile memory port between the
//  CPU data path (m0, from the servile mux mem side) and a secondary requester (m1:

---
 rtl/servile_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_servile_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/servile_mem_arbiter.sv
// servile_mem_arbiter: two-master Wishbone arbiter for the servile memory port.
// m0 is the CPU data path and m1 is a secondary requester (loader/debug/DMA).
// Grant is registered in IDLE and held for one access; the slave side carries
// the owner's fields and strobe only while BUSY.
//
// Handshake: a master holds stb high until it sees its own ack, which is a
// one-cycle combinational echo of i_wb_s_ack. Dropping stb before the ack
// abandons the access. At least one IDLE cycle separates two slave accesses.
//
// Optional feature: define SERVILE_ARB_TIMEOUT_EN to enable a BUSY watchdog
// that completes the access with rdt=0 and pulses o_timeout after TIMEOUT_CYC
// cycles without an ack. Without it, o_timeout is tied low.
module servile_mem_arbiter #(
    parameter logic FIXED_PRIO  = 1'b0,
    parameter int   TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_m0_adr,
    input  logic [31:0] i_wb_m0_dat,
    input  logic [3:0]  i_wb_m0_sel,
    input  logic        i_wb_m0_we,
    input  logic        i_wb_m0_stb,
    output logic [31:0] o_wb_m0_rdt,
    output logic        o_wb_m0_ack,
    input  logic [31:0] i_wb_m1_adr,
    input  logic [31:0] i_wb_m1_dat,
    input  logic [3:0]  i_wb_m1_sel,
    input  logic        i_wb_m1_we,
    input  logic        i_wb_m1_stb,
    output logic [31:0] o_wb_m1_rdt,
    output logic        o_wb_m1_ack,
    output logic [31:0] o_wb_s_adr,
    output logic [31:0] o_wb_s_dat,
    output logic [3:0]  o_wb_s_sel,
    output logic        o_wb_s_we,
    output logic        o_wb_s_stb,
    input  logic [31:0] i_wb_s_rdt,
    input  logic        i_wb_s_ack,
    output logic        o_busy,
    output logic        o_owner,
    output logic        o_timeout
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    // The watchdog counter is 16 bits wide, so its limit must fit.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("servile_mem_arbiter: TIMEOUT_CYC must be in 1..65535");
    end

    state_t state;
    logic   owner;
    logic   last;
    logic   busy;
    logic   own_stb;
    logic   grant;
    logic   timeout_hit;
    logic   done;

    assign busy    = (state == S_BUSY);
    assign own_stb = owner ? i_wb_m1_stb : i_wb_m0_stb;

    // Contention goes to m0 in fixed mode, otherwise to the master not served last.
    assign grant = (i_wb_m0_stb && i_wb_m1_stb) ? (FIXED_PRIO ? 1'b0 : ~last)
                                                : i_wb_m1_stb;

`ifdef SERVILE_ARB_TIMEOUT_EN
    logic [15:0] cnt;

    // Watchdog: cleared on grant, counts BUSY cycles that pass without an ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 16'd0;
        end else if (!busy) begin
            cnt <= 16'd0;
        end else if (!i_wb_s_ack) begin
            cnt <= cnt + 16'd1;
        end
    end

    // A real ack in the same cycle takes precedence over the watchdog.
    assign timeout_hit = busy && own_stb && !i_wb_s_ack
                      && (cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // The access completes on the slave ack or on a watchdog abort.
    assign done = busy && (i_wb_s_ack || timeout_hit);

    // Arbitration FSM: grant registered from IDLE, released on ack, abort or timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_wb_m0_stb || i_wb_m1_stb) begin
                        state <= S_BUSY;
                        owner <= grant;
                    end
                end
                S_BUSY: begin
                    if (i_wb_s_ack || !own_stb || timeout_hit) begin
                        state <= S_IDLE;
                        last  <= owner;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_wb_s_adr  = owner ? i_wb_m1_adr : i_wb_m0_adr;
    assign o_wb_s_dat  = owner ? i_wb_m1_dat : i_wb_m0_dat;
    assign o_wb_s_sel  = owner ? i_wb_m1_sel : i_wb_m0_sel;
    assign o_wb_s_we   = owner ? i_wb_m1_we  : i_wb_m0_we;
    assign o_wb_s_stb  = busy && own_stb && !timeout_hit;

    assign o_wb_m0_ack = done && !owner;
    assign o_wb_m1_ack = done && owner;
    assign o_wb_m0_rdt = timeout_hit ? 32'h0 : i_wb_s_rdt;
    assign o_wb_m1_rdt = timeout_hit ? 32'h0 : i_wb_s_rdt;

    assign o_busy    = busy;
    assign o_owner   = owner;
    assign o_timeout = timeout_hit;

endmodule

// File: tb/tb_servile_mem_arbiter.sv
// Directed bench for servile_mem_arbiter. Instance u_rr is round-robin and
// u_fx is fixed-priority; both see the same inputs and stay in lock-step.
module tb_servile_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_rdt;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_stb, m1_we, m1_stb, s_ack;

    logic [31:0] a_m0_rdt, a_m1_rdt, a_s_adr, a_s_dat;
    logic [3:0]  a_s_sel;
    logic        a_m0_ack, a_m1_ack, a_s_we, a_s_stb, a_busy, a_owner, a_timeout;
    logic [31:0] b_m0_rdt, b_m1_rdt, b_s_adr, b_s_dat;
    logic [3:0]  b_s_sel;
    logic        b_m0_ack, b_m1_ack, b_s_we, b_s_stb, b_busy, b_owner, b_timeout;

    int n_pass  = 0;
    int n_total = 0;

    logic exp_rr[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    servile_mem_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT_CYC(8)) u_rr (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
        .i_wb_m0_we(m0_we), .i_wb_m0_stb(m0_stb),
        .o_wb_m0_rdt(a_m0_rdt), .o_wb_m0_ack(a_m0_ack),
        .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
        .i_wb_m1_we(m1_we), .i_wb_m1_stb(m1_stb),
        .o_wb_m1_rdt(a_m1_rdt), .o_wb_m1_ack(a_m1_ack),
        .o_wb_s_adr(a_s_adr), .o_wb_s_dat(a_s_dat), .o_wb_s_sel(a_s_sel),
        .o_wb_s_we(a_s_we), .o_wb_s_stb(a_s_stb),
        .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack),
        .o_busy(a_busy), .o_owner(a_owner), .o_timeout(a_timeout)
    );

    servile_mem_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT_CYC(8)) u_fx (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
        .i_wb_m0_we(m0_we), .i_wb_m0_stb(m0_stb),
        .o_wb_m0_rdt(b_m0_rdt), .o_wb_m0_ack(b_m0_ack),
        .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
        .i_wb_m1_we(m1_we), .i_wb_m1_stb(m1_stb),
        .o_wb_m1_rdt(b_m1_rdt), .o_wb_m1_ack(b_m1_ack),
        .o_wb_s_adr(b_s_adr), .o_wb_s_dat(b_s_dat), .o_wb_s_sel(b_s_sel),
        .o_wb_s_we(b_s_we), .o_wb_s_stb(b_s_stb),
        .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack),
        .o_busy(b_busy), .o_owner(b_owner), .o_timeout(b_timeout)
    );

    // Clock: 10 time-unit period
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        m0_adr = 32'h0; m0_dat = 32'h0; m0_sel = 4'h0; m0_we = 1'b0; m0_stb = 1'b0;
        m1_adr = 32'h0; m1_dat = 32'h0; m1_sel = 4'h0; m1_we = 1'b0; m1_stb = 1'b0;
        s_rdt = 32'hA5A5_0001; s_ack = 1'b0;
        settle();

        // Reset values
        chk("rst_busy", {31'b0, a_busy}, 32'd0);
        chk("rst_owner", {31'b0, a_owner}, 32'd0);
        chk("rst_s_stb", {31'b0, a_s_stb}, 32'd0);
        chk("rst_timeout", {31'b0, a_timeout}, 32'd0);
        chk("rst_rdt_follow", a_m1_rdt, 32'hA5A5_0001);
        tick(); tick();
        i_rst_n = 1'b1;
        tick();

        // Reset asserted mid-BUSY clears everything immediately
        m0_stb = 1'b1;
        tick();
        chk("t1_busy_before", {31'b0, a_busy}, 32'd1);
        s_ack = 1'b1;
        i_rst_n = 1'b0;
        settle();
        chk("t1_s_stb", {31'b0, a_s_stb}, 32'd0);
        chk("t1_busy", {31'b0, a_busy}, 32'd0);
        chk("t1_m0_ack", {31'b0, a_m0_ack}, 32'd0);
        chk("t1_m1_ack", {31'b0, a_m1_ack}, 32'd0);
        m0_stb = 1'b0; s_ack = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();

        // Contention: round-robin alternates, fixed priority keeps m0
        m0_stb = 1'b1; m1_stb = 1'b1;
        for (int r = 0; r < 6; r++) begin
            tick();
            chk($sformatf("t3_rr_owner%0d", r), {31'b0, a_owner}, {31'b0, exp_rr[r]});
            chk($sformatf("t3_fx_owner%0d", r), {31'b0, b_owner}, 32'd0);
            s_ack = 1'b1;
            settle();
            chk($sformatf("t3_rr_m1_ack%0d", r), {31'b0, a_m1_ack}, {31'b0, exp_rr[r]});
            chk($sformatf("t3_fx_m0_ack%0d", r), {31'b0, b_m0_ack}, 32'd1);
            tick();
            s_ack = 1'b0;
            settle();
            chk($sformatf("t3_gap_stb%0d", r), {31'b0, a_s_stb}, 32'd0);
            chk($sformatf("t3_gap_busy%0d", r), {31'b0, a_busy}, 32'd0);
        end
        // m0 stops requesting: fixed-priority instance now serves m1
        m0_stb = 1'b0;
        tick();
        chk("t3_fx_m1_granted", {31'b0, b_owner}, 32'd1);
        s_ack = 1'b1;
        settle();
        chk("t3_fx_m1_ack", {31'b0, b_m1_ack}, 32'd1);
        tick();
        s_ack = 1'b0; m1_stb = 1'b0;
        tick();

        // m0 read at 0x100, slave acks 2 cycles after s_stb rises
        m0_adr = 32'h100; m0_we = 1'b0; m0_sel = 4'hF; m0_stb = 1'b1;
        settle();
        chk("t2_stb_latency", {31'b0, a_s_stb}, 32'd0);
        tick();
        chk("t2_s_stb", {31'b0, a_s_stb}, 32'd1);
        chk("t2_s_adr", a_s_adr, 32'h100);
        tick(); tick();
        s_ack = 1'b1; s_rdt = 32'hDEAD_BEEF;
        settle();
        chk("t2_m0_ack", {31'b0, a_m0_ack}, 32'd1);
        chk("t2_m0_rdt", a_m0_rdt, 32'hDEAD_BEEF);
        chk("t2_m1_ack", {31'b0, a_m1_ack}, 32'd0);
        tick();
        s_ack = 1'b0; m0_stb = 1'b0;
        settle();
        chk("t2_ack_one_cycle", {31'b0, a_m0_ack}, 32'd0);
        chk("t2_idle", {31'b0, a_busy}, 32'd0);
        tick();

        // m1 write waits while m0 owns the port
        m0_adr = 32'h200; m0_stb = 1'b1;
        tick();
        m1_adr = 32'h300; m1_dat = 32'h1234_5678; m1_sel = 4'b0011; m1_we = 1'b1; m1_stb = 1'b1;
        settle();
        chk("t4_m0_owns_adr", a_s_adr, 32'h200);
        chk("t4_m0_owns_we", {31'b0, a_s_we}, 32'd0);
        tick();
        chk("t4_still_m0", {31'b0, a_owner}, 32'd0);
        chk("t4_m1_no_ack", {31'b0, a_m1_ack}, 32'd0);
        s_ack = 1'b1;
        settle();
        chk("t4_m0_ack", {31'b0, a_m0_ack}, 32'd1);
        chk("t4_m1_ack_low", {31'b0, a_m1_ack}, 32'd0);
        tick();
        s_ack = 1'b0; m0_stb = 1'b0;
        settle();
        chk("t4_idle_gap", {31'b0, a_s_stb}, 32'd0);
        tick();
        chk("t4_m1_owner", {31'b0, a_owner}, 32'd1);
        chk("t4_s_stb", {31'b0, a_s_stb}, 32'd1);
        chk("t4_s_adr", a_s_adr, 32'h300);
        chk("t4_s_dat", a_s_dat, 32'h1234_5678);
        chk("t4_s_sel", {28'b0, a_s_sel}, 32'h3);
        chk("t4_s_we", {31'b0, a_s_we}, 32'd1);
        s_ack = 1'b1;
        settle();
        chk("t4_m1_ack", {31'b0, a_m1_ack}, 32'd1);
        chk("t4_m0_ack_low", {31'b0, a_m0_ack}, 32'd0);
        tick();
        s_ack = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        tick();

        // Owner abandons the access before the ack
        m1_stb = 1'b1;
        tick();
        chk("t5_busy", {31'b0, a_busy}, 32'd1);
        m1_stb = 1'b0;
        settle();
        chk("t5_no_ack", {31'b0, a_m1_ack}, 32'd0);
        tick();
        chk("t5_s_stb", {31'b0, a_s_stb}, 32'd0);
        chk("t5_idle", {31'b0, a_busy}, 32'd0);
        chk("t5_no_ack_after", {31'b0, a_m1_ack}, 32'd0);
        tick();

        // Slave never acks
        s_rdt = 32'hCAFE_F00D;
        m0_stb = 1'b1;
        tick();
`ifdef SERVILE_ARB_TIMEOUT_EN
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("t6_wait_to%0d", c), {31'b0, a_timeout}, 32'd0);
            chk($sformatf("t6_wait_stb%0d", c), {31'b0, a_s_stb}, 32'd1);
            tick();
        end
        chk("t6_timeout", {31'b0, a_timeout}, 32'd1);
        chk("t6_to_ack", {31'b0, a_m0_ack}, 32'd1);
        chk("t6_to_rdt", a_m0_rdt, 32'h0);
        chk("t6_to_stb", {31'b0, a_s_stb}, 32'd0);
        tick();
        m0_stb = 1'b0;
        settle();
        chk("t6_to_pulse", {31'b0, a_timeout}, 32'd0);
        chk("t6_to_idle", {31'b0, a_busy}, 32'd0);
`else
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("t6_hold_busy%0d", c), {31'b0, a_busy}, 32'd1);
            chk($sformatf("t6_hold_to%0d", c), {31'b0, a_timeout}, 32'd0);
            tick();
        end
        chk("t6_no_ack", {31'b0, a_m0_ack}, 32'd0);
        m0_stb = 1'b0;
        tick();
        chk("t6_idle", {31'b0, a_busy}, 32'd0);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
